// File: rtl/fetch_unit.sv
// PC generation and fetch sequencing in front of a 1-cycle registered instruction memory.
// Optional FETCH_PERF_EN adds transfer and stall counters.
module fetch_unit #(
    parameter int                  PC_WIDTH  = 32,
    parameter int                  I_WIDTH   = 32,
    parameter int                  IMEM_SIZE = 2**15,
    parameter int                  ADD_WIDTH = $clog2(IMEM_SIZE >> 2),
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [ADD_WIDTH-1:0] imem_addr,
    output logic                 imem_go,
    input  logic [I_WIDTH-1:0]   imem_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [I_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]  out_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt,
`endif
    output logic                 misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PC_WIDTH-1:0]  fetch_pc;
    logic [PC_WIDTH-1:0]  resp_pc;
    logic                 resp_valid;
    logic                 redir_ok;
    logic                 redir_bad;
    logic                 hold;
    logic                 go;

    assign redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign hold      = resp_valid & ~out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: redirects win over the BOOT->RUN step
    always_comb begin
        state_next = state;
        if (redir_ok) begin
            state_next = RUN;
        end else if (redir_bad) begin
            state_next = HALT;
        end else if (state == BOOT) begin
            state_next = RUN;
        end
    end

    // Output logic: go doubles as the memory clock-enable, so it must drop while holding
    always_comb begin
        go = 1'b0;
        if (state == RUN) begin
            go = ~hold & ~redirect_valid;
        end
    end

    assign imem_go   = go;
    assign imem_addr = fetch_pc[ADD_WIDTH+1:2];
    assign out_valid = resp_valid;
    assign out_pc    = resp_pc;
    assign out_instr = imem_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            resp_pc      <= '0;
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redir_ok) begin
            fetch_pc     <= redirect_pc;
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redir_bad) begin
            resp_valid   <= 1'b0;
            misalign_err <= 1'b1;
        end else if (go) begin
            resp_pc      <= fetch_pc;
            resp_valid   <= 1'b1;
            fetch_pc     <= fetch_pc + PC_WIDTH'(4);
        end else if (!hold) begin
            resp_valid   <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (resp_valid && out_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (hold) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected {pc, instr} transfers plus cycle-exact checks.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [12:0] imem_addr;
    logic        imem_go;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    logic [12:0] imem_addr1;
    logic        imem_go1;
    logic [31:0] imem_instr1;
    logic        out_valid1;
    logic [31:0] out_instr1;
    logic [31:0] out_pc1;
    logic        misalign_err1;

`ifdef FETCH_PERF_EN
    logic [31:0] pf0, ps0, pf1, ps1;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_unit u0 (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_go(imem_go), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(pf0), .perf_stall_cnt(ps0),
`endif
        .misalign_err(misalign_err)
    );

    fetch_unit #(.RESET_PC(32'd32764)) u1 (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .imem_addr(imem_addr1), .imem_go(imem_go1), .imem_instr(imem_instr1),
        .out_valid(out_valid1), .out_ready(1'b1),
        .out_instr(out_instr1), .out_pc(out_pc1),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(pf1), .perf_stall_cnt(ps1),
`endif
        .misalign_err(misalign_err1)
    );

    function automatic logic [31:0] mem_word(input logic [12:0] w);
        if (w < 13'd4) return 32'h11 * (32'(w) + 32'd1);
        return 32'hC000_0000 | 32'(w);
    endfunction

    // memory models: registered read, held while go=0
    always @(posedge clk) begin
        if (imem_go) imem_instr <= mem_word(imem_addr);
        if (imem_go1) imem_instr1 <= {19'd0, imem_addr1};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pc(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc[14:2])});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: a redirect in the same cycle flushes the response
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_xfer: got pc %0h, expected no transfer", out_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("xfer_pc", {32'd0, out_pc}, {32'd0, e[63:32]});
                chk("xfer_instr", {32'd0, out_instr}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_go", 64'(imem_go), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_err", 64'(misalign_err), 64'd0);

        push_pc(32'h0);
        push_pc(32'h4);
        rst_n = 1'b1;                                    // cycle 0 (BOOT)
        @(negedge clk);
        chk("boot_go", 64'(imem_go), 64'd0);
        chk("boot_valid", 64'(out_valid), 64'd0);
        step();                                          // cycle 1
        @(negedge clk);
        chk("c1_go", 64'(imem_go), 64'd1);
        chk("c1_addr", 64'(imem_addr), 64'd0);
        chk("c1_valid", 64'(out_valid), 64'd0);
        chk("wrap_addr_top", 64'(imem_addr1), 64'd8191);
        step();                                          // cycle 2
        @(negedge clk);
        chk("c2_valid", 64'(out_valid), 64'd1);
        chk("c2_addr", 64'(imem_addr), 64'd1);
        chk("wrap_pc_top", 64'(out_pc1), 64'd32764);
        chk("wrap_addr_zero", 64'(imem_addr1), 64'd0);
        chk("wrap_instr_top", 64'(out_instr1), 64'd8191);
        step();
        out_ready = 1'b0;                                // cycles 3..5 stalled
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_go", 64'(imem_go), 64'd0);
            chk("stall_pc", 64'(out_pc), 64'h4);
            chk("stall_instr", 64'(out_instr), 64'h22);
            if (i == 0) begin
                chk("wrap_pc_next", 64'(out_pc1), 64'd32768);
                chk("wrap_instr_next", 64'(out_instr1), 64'd0);
            end
            step();
        end
        out_ready = 1'b1;                                // cycle 6: pc 4 transfers
`ifdef FETCH_PERF_EN
        @(negedge clk);
        chk("perf_stall", 64'(ps0), 64'd3);
`endif
        push_pc(32'h40);
        step();
        redirect_valid = 1'b1;                           // cycle 7: flush pc 8
        redirect_pc = 32'h40;
        @(negedge clk);
        chk("c7_pc", 64'(out_pc), 64'h8);
        chk("redir_go", 64'(imem_go), 64'd0);
        step();
        redirect_valid = 1'b0;                           // cycle 8
        @(negedge clk);
        chk("c8_valid", 64'(out_valid), 64'd0);
        chk("c8_addr", 64'(imem_addr), 64'h10);
        step();                                          // cycle 9: pc 0x40
        @(negedge clk);
        chk("c9_pc", 64'(out_pc), 64'h40);
        step();
        out_ready = 1'b0;                                // cycle 10: pc 0x44 held
        push_pc(32'h100);
        push_pc(32'h104);
        step();
        redirect_valid = 1'b1;                           // cycle 11: redirect under hold
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("hold_redir_go", 64'(imem_go), 64'd0);
        step();
        redirect_valid = 1'b0;                           // cycle 12
        out_ready = 1'b1;
        @(negedge clk);
        chk("c12_valid", 64'(out_valid), 64'd0);
        chk("c12_addr", 64'(imem_addr), 64'h40);
        step();                                          // cycle 13: pc 0x100
        step();                                          // cycle 14: pc 0x104
        step();
        redirect_valid = 1'b1;                           // cycle 15: misaligned
        redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_err", 64'(misalign_err), 64'd1);
            chk("halt_go", 64'(imem_go), 64'd0);
            chk("halt_valid", 64'(out_valid), 64'd0);
            step();
        end
        push_pc(32'h80);
        redirect_valid = 1'b1;                           // cycle N: recover to 0x80
        redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;                           // N+1
        @(negedge clk);
        chk("recover_err", 64'(misalign_err), 64'd0);
        chk("recover_go", 64'(imem_go), 64'd1);
        chk("recover_addr", 64'(imem_addr), 64'h20);
        chk("recover_valid", 64'(out_valid), 64'd0);
        step();                                          // N+2: pc 0x80
        @(negedge clk);
        chk("recover_pc", 64'(out_pc), 64'h80);
        step();
        #1;
        rst_n = 1'b0;                                    // asynchronous mid-stream reset
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_go", 64'(imem_go), 64'd0);
        chk("midrst_pc", 64'(out_pc), 64'd0);
        push_pc(32'h0);
        push_pc(32'h4);
        step();
        rst_n = 1'b1;                                    // cycle 0'
        step();                                          // cycle 1'
        @(negedge clk);
        chk("restart_addr", 64'(imem_addr), 64'd0);
        chk("restart_go", 64'(imem_go), 64'd1);
        step();                                          // cycle 2': pc 0
        @(negedge clk);
        chk("restart_pc", 64'(out_pc), 64'd0);
        step();                                          // cycle 3': pc 4
        step();
        out_ready = 1'b0;
        repeat (3) step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC generation and fetch-sequencing stage directly upstream of the instruction memory.
- Drives the memory's word address and read-enable (`go`), and tracks the memory's 1-cycle registered read latency.
- Presents each returned instruction with its PC to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the wrong-path response; stalls by freezing the memory's output register.

Parameters:
- PC_WIDTH, 32, byte-address PC width
- I_WIDTH, 32, instruction width
- IMEM_SIZE, 2**15, instruction memory size in bytes
- ADD_WIDTH, $clog2(IMEM_SIZE>>2), word-address width to memory
- RESET_PC, 0, byte PC fetched first after reset (must be 4-byte aligned)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_WIDTH  target byte PC
- imem_addr  out  ADD_WIDTH  word address to instruction memory
- imem_go  out  1  memory read-enable/clock-enable
- imem_instr  in  I_WIDTH  memory read data (valid one cycle after a go=1 cycle; held while go=0)
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts instruction
- out_instr  out  I_WIDTH  instruction to decode
- out_pc  out  PC_WIDTH  byte PC of out_instr
- misalign_err  out  1  sticky: misaligned redirect received

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state=BOOT, fetch_pc=RESET_PC, resp_valid=0, resp_pc=0, misalign_err=0.
  - Outputs: imem_go=0, out_valid=0, out_pc=0.
- Output mapping:
  - imem_addr = fetch_pc[ADD_WIDTH+1:2] (combinational). Addresses wrap modulo IMEM_SIZE; upper PC bits are ignored for addressing, but out_pc carries the full PC.
  - out_valid=resp_valid, out_pc=resp_pc, out_instr=imem_instr. No extra buffering: the memory output register is the pipeline register.
- hold = resp_valid & ~out_ready.
- imem_go = (state==RUN) & ~hold & ~redirect_valid.
- FSM:
  - BOOT: one cycle after reset release, no fetch -> RUN.
  - RUN: normal fetch; a misaligned redirect -> HALT.
  - HALT: imem_go=0, misalign_err=1; an aligned redirect -> RUN.
- Per-cycle update, in priority order:
  1. redirect_valid=1 with redirect_pc[1:0]==0:
     - fetch_pc<=redirect_pc; resp_valid<=0 (in-flight/held instruction dropped, even if out_ready=1 this cycle).
     - state<=RUN; misalign_err<=0.
  2. redirect_valid=1 with redirect_pc[1:0]!=0:
     - resp_valid<=0; state<=HALT; misalign_err<=1; fetch_pc unchanged.
  3. imem_go=1:
     - resp_pc<=fetch_pc; resp_valid<=1; fetch_pc<=fetch_pc+4 (modulo 2**PC_WIDTH).
  4. hold=1: all registers hold. imem_go=0, so the memory keeps imem_instr stable.
  5. Otherwise: resp_valid<=0.
- Latency:
  - Reset release at cycle 0: first go at cycle 1, out_valid at cycle 2 with out_pc=RESET_PC.
  - Redirect at cycle N: go with new PC at N+1, out_valid at N+2.
- Throughput: 1 instruction/cycle with out_ready held high.
- Handshake: a transfer occurs when out_valid & out_ready. out_instr and out_pc stay stable while out_valid & ~out_ready, unless a redirect flushes them.
- Redirect while in BOOT: honoured; the BOOT cycle is still consumed and the next state is RUN.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); the in-flight response is discarded.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every completed out_valid&out_ready transfer.
  - perf_stall_cnt increments on every cycle with hold=1.
  - Both wrap at 2**32; neither is affected by redirect.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, out_ready=1, memory words 0..3 = 0x11,0x22,0x33,0x44 -> out_valid first at cycle 2; out_pc 0,4,8,12 on consecutive cycles with matching instructions; imem_addr 0,1,2,3.
- Stall: out_ready=0 for 3 cycles while out_pc=4 -> imem_go=0; out_instr=0x22 and out_pc=4 stable; after release, the next transfer is pc=8 with no skip or duplicate. With FETCH_PERF_EN: perf_stall_cnt=3.
- Redirect to 0x40 while out_valid=1 for pc=8 -> that instruction is dropped; pc=0x40 is valid two cycles later; no pc=0xC output.
- Redirect with hold active (out_ready=0) -> held instruction discarded; new-path instruction delivered at N+2.
- Redirect to 0x42 -> misalign_err=1, imem_go=0, out_valid=0 indefinitely; a later redirect to 0x80 clears err and out_pc=0x80 appears at N+2.
- Wrap: RESET_PC=IMEM_SIZE-4 -> imem_addr=WORDS-1, then 0; out_pc=IMEM_SIZE-4, then IMEM_SIZE. Also assert rst_n low mid-stream -> out_valid=0 immediately, and fetching restarts at RESET_PC.
